// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC, sequences IDLE/RUN/HALTED, resolves
// branches and calls through the external label->target LUT, and keeps a return stack.
module pc_sequencer #(
   parameter logic [11:0] START_PC    = 12'd0,
   parameter int          STACK_DEPTH = 4,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt_req,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic             call_en,
   input  logic             ret_en,
   input  logic [7:0]       branch_label,
   input  logic [11:0]      lut_target,
   output logic [7:0]       lut_label,
   output logic [11:0]      pc,
   output logic             running,
   output logic             done,
   output logic             stack_err,
   output logic [CNT_W-1:0] instr_count,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
   localparam int              IDX_W   = $clog2(STACK_DEPTH);
   localparam logic [SP_W-1:0] DEPTH_V = SP_W'(STACK_DEPTH);
   localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

   state_t             state_q, state_d;
   logic [11:0]        pc_q, pc_d;
   logic [SP_W-1:0]    sp_q, sp_d;
   logic               err_q, err_d;
   logic               run_q, run_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [11:0]        stack_q [STACK_DEPTH];
   logic               push_en;
   logic [11:0]        pc_inc;
   logic [SP_W-1:0]    sp_m1;
   logic [11:0]        stack_top;
   logic [CNT_W-1:0]   cnt_inc;

   assign pc_inc    = pc_q + 12'd1;
   assign sp_m1     = sp_q - SP_ONE;
   assign stack_top = stack_q[sp_m1[IDX_W-1:0]];
   // Retired-instruction counter saturates instead of wrapping.
   assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      sp_d    = sp_q;
      err_d   = err_q;
      run_d   = run_q;
      done_d  = done_q;
      cnt_d   = cnt_q;
      push_en = 1'b0;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               state_d = S_RUN;
               pc_d    = START_PC;
               sp_d    = '0;
               err_d   = 1'b0;
               cnt_d   = '0;
               run_d   = 1'b1;
               done_d  = 1'b0;
            end
         end
         S_RUN: begin
            if (halt_req && !stall) begin
               state_d = S_HALTED;
               run_d   = 1'b0;
               done_d  = 1'b1;
               cnt_d   = cnt_inc;
            end else if (!stall) begin
               cnt_d = cnt_inc;
               if (call_en) begin
                  pc_d = lut_target;
                  if (sp_q < DEPTH_V) begin
                     push_en = 1'b1;
                     sp_d    = sp_q + SP_ONE;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (ret_en) begin
                  if (sp_q != '0) begin
                     pc_d = stack_top;
                     sp_d = sp_m1;
                  end else begin
                     err_d = 1'b1;
                     pc_d  = pc_inc;
                  end
               end else if (branch_taken) begin
                  pc_d = lut_target;
               end else begin
                  pc_d = pc_inc;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= START_PC;
         sp_q    <= '0;
         err_q   <= 1'b0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
         err_q   <= err_d;
         run_q   <= run_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stack contents need no reset; validity is tracked solely by sp_q.
   always_ff @(posedge clk) begin
      if (push_en) stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
   end

   assign lut_label   = branch_label;
   assign pc          = pc_q;
   assign running     = run_q;
   assign done        = done_q;
   assign stack_err   = err_q;
   assign instr_count = cnt_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: driver pushes hand-computed expected state
// per cycle; a negedge monitor pops and compares.
module tb_pc_sequencer;

   localparam int W = 31;  // {pc[12], running, done, stack_err, count[16]}

   localparam logic [5:0] C_NONE  = 6'b000000;
   localparam logic [5:0] C_START = 6'b100000;
   localparam logic [5:0] C_HALT  = 6'b010000;
   localparam logic [5:0] C_STALL = 6'b001000;
   localparam logic [5:0] C_BR    = 6'b000100;
   localparam logic [5:0] C_CALL  = 6'b000010;
   localparam logic [5:0] C_RET   = 6'b000001;

   localparam logic [2:0] F_IDLE  = 3'b000;
   localparam logic [2:0] F_RUN   = 3'b100;
   localparam logic [2:0] F_HALT  = 3'b010;
   localparam logic [2:0] F_RUNE  = 3'b101;
   localparam logic [2:0] F_HALTE = 3'b011;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, halt_req, stall, branch_taken, call_en, ret_en;
   logic [7:0]  branch_label;
   logic [11:0] lut_target, lut_target_s;
   logic [7:0]  lut_label, lut_label_s;
   logic [11:0] pc, pc_s;
   logic        running, done, stack_err;
   logic        running_s, done_s, stack_err_s;
   logic [15:0] instr_count;
   logic [2:0]  instr_count_s;
   logic [1:0]  dbg_state, dbg_state_s;

   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [11:0] lut_fn(input logic [7:0] lbl);
      case (lbl)
         8'd1:    return 12'd10;
         8'd2:    return 12'd20;
         8'd3:    return 12'd633;
         8'd4:    return 12'd4095;
         8'd8:    return 12'd451;
         default: return 12'd1024 + {4'd0, lbl};
      endcase
   endfunction

   assign lut_target   = lut_fn(lut_label);
   assign lut_target_s = lut_fn(lut_label_s);

   pc_sequencer #(.START_PC(12'd0), .STACK_DEPTH(4), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
      .branch_taken(branch_taken), .call_en(call_en), .ret_en(ret_en),
      .branch_label(branch_label), .lut_target(lut_target), .lut_label(lut_label),
      .pc(pc), .running(running), .done(done), .stack_err(stack_err),
      .instr_count(instr_count), .dbg_state(dbg_state)
   );

   // Narrow-counter copy sharing the same stimulus, used for the saturation check.
   pc_sequencer #(.START_PC(12'd0), .STACK_DEPTH(4), .CNT_W(3)) u_sat (
      .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
      .branch_taken(branch_taken), .call_en(call_en), .ret_en(ret_en),
      .branch_label(branch_label), .lut_target(lut_target_s), .lut_label(lut_label_s),
      .pc(pc_s), .running(running_s), .done(done_s), .stack_err(stack_err_s),
      .instr_count(instr_count_s), .dbg_state(dbg_state_s)
   );

   // Clock and reset
   always #5 clk = ~clk;

   // Monitor: one expected entry per negedge
   always @(negedge clk) begin
      logic [W-1:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {pc, running, done, stack_err, instr_count};
         n_cmp++;
         if (a !== e) begin
            n_err++;
            $display("FAIL cmp%0d: got pc=%0d run/done/err=%b cnt=%0d, want pc=%0d run/done/err=%b cnt=%0d",
                     n_cmp, a[30:19], a[18:16], a[15:0], e[30:19], e[18:16], e[15:0]);
         end
      end
   end

   // Driver
   task automatic step(input logic [5:0] ctl, input logic [7:0] lbl,
                       input logic [11:0] e_pc, input logic [2:0] e_fl,
                       input logic [15:0] e_cnt);
      {start, halt_req, stall, branch_taken, call_en, ret_en} = ctl;
      branch_label = lbl;
      @(posedge clk);
      #1;
      exp_q.push_back({e_pc, e_fl, e_cnt});
   endtask

   initial begin
      reset = 1'b1;
      {start, halt_req, stall, branch_taken, call_en, ret_en} = C_NONE;
      branch_label = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back({12'd0, F_IDLE, 16'd0});
      @(negedge clk);
      #1;
      reset = 1'b0;

      // Idle ignores control; start then sequential fetch; halt
      step(C_BR | C_CALL, 8'd8, 12'd0, F_IDLE, 16'd0);
      step(C_START, 8'd0, 12'd0, F_RUN, 16'd0);
      for (int i = 1; i <= 5; i++) step(C_NONE, 8'd0, 12'(i), F_RUN, 16'(i));
      step(C_HALT, 8'd0, 12'd5, F_HALT, 16'd6);

      // Branch through the LUT
      step(C_START, 8'd0, 12'd0, F_RUN, 16'd0);
      for (int i = 1; i <= 3; i++) step(C_NONE, 8'd0, 12'(i), F_RUN, 16'(i));
      step(C_BR, 8'd8, 12'd451, F_RUN, 16'd4);
      step(C_NONE, 8'd0, 12'd452, F_RUN, 16'd5);

      // Call at pc=10 and return
      step(C_BR, 8'd1, 12'd10, F_RUN, 16'd6);
      step(C_CALL, 8'd3, 12'd633, F_RUN, 16'd7);
      step(C_NONE, 8'd0, 12'd634, F_RUN, 16'd8);
      step(C_RET, 8'd0, 12'd11, F_RUN, 16'd9);

      // Nested calls overflow, then unwind and underflow
      step(C_CALL, 8'd20, 12'd1044, F_RUN, 16'd10);
      step(C_CALL, 8'd21, 12'd1045, F_RUN, 16'd11);
      step(C_CALL, 8'd22, 12'd1046, F_RUN, 16'd12);
      step(C_CALL, 8'd23, 12'd1047, F_RUN, 16'd13);
      step(C_CALL, 8'd24, 12'd1048, F_RUNE, 16'd14);
      step(C_RET, 8'd0, 12'd1047, F_RUNE, 16'd15);
      step(C_RET, 8'd0, 12'd1046, F_RUNE, 16'd16);
      step(C_RET, 8'd0, 12'd1045, F_RUNE, 16'd17);
      step(C_RET, 8'd0, 12'd12, F_RUNE, 16'd18);
      step(C_RET, 8'd0, 12'd13, F_RUNE, 16'd19);

      // Stall holds off halt; HALTED frozen; start clears
      step(C_BR, 8'd2, 12'd20, F_RUNE, 16'd20);
      step(C_STALL | C_HALT, 8'd0, 12'd20, F_RUNE, 16'd20);
      step(C_STALL | C_HALT, 8'd0, 12'd20, F_RUNE, 16'd20);
      step(C_STALL | C_HALT | C_BR, 8'd8, 12'd20, F_RUNE, 16'd20);
      step(C_HALT, 8'd0, 12'd20, F_HALTE, 16'd21);
      step(C_BR | C_RET, 8'd8, 12'd20, F_HALTE, 16'd21);
      step(C_START, 8'd0, 12'd0, F_RUN, 16'd0);
      step(C_START, 8'd0, 12'd1, F_RUN, 16'd1);

      // PC wrap, pushed return address wraps too
      step(C_BR, 8'd4, 12'd4095, F_RUN, 16'd2);
      step(C_NONE, 8'd0, 12'd0, F_RUN, 16'd3);
      step(C_BR, 8'd4, 12'd4095, F_RUN, 16'd4);
      step(C_CALL, 8'd3, 12'd633, F_RUN, 16'd5);
      step(C_RET, 8'd0, 12'd0, F_RUN, 16'd6);
      step(C_CALL, 8'd3, 12'd633, F_RUN, 16'd7);

      // Reset mid-call
      {start, halt_req, stall, branch_taken, call_en, ret_en} = C_NONE;
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      exp_q.push_back({12'd0, F_IDLE, 16'd0});
      @(negedge clk);
      #1;
      reset = 1'b0;
      step(C_NONE, 8'd0, 12'd0, F_IDLE, 16'd0);
      step(C_START, 8'd0, 12'd0, F_RUN, 16'd0);
      step(C_RET, 8'd0, 12'd1, F_RUNE, 16'd1);
      for (int i = 2; i <= 9; i++) step(C_NONE, 8'd0, 12'(i), F_RUNE, 16'(i));
      {start, halt_req, stall, branch_taken, call_en, ret_en} = C_NONE;

      // Drain scoreboard with a bounded wait
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end

      // Narrow counter has retired 9 since start and must sit at all-ones
      n_cmp++;
      if (instr_count_s !== 3'd7) begin
         n_err++;
         $display("FAIL sat_count: got %0d, want 7", instr_count_s);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
